memory_unit: RTL and testbench
==============================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instr_in, input, 32, instruction leaving execute stage.
REQ-004 SHALL have port branch_in, input, 1, flush; the instruction captured this edge becomes NOP.
REQ-005 SHALL have ports exec_rn/exec_rm/exec_rs, input, 4 each, source registers of the instruction currently in execute.
REQ-006 SHALL have port exec_use, input, 3, read-enables for {rs,rm,rn} (bit2..bit0).
REQ-007 SHALL have port mem_ready, input, 1, data-memory acknowledge.
REQ-008 SHALL have port rd, output, 4, forwarding tag to execute stage; 4'h0 when rd_valid=0.
REQ-009 SHALL have port rd_valid, output, 1, R holds a register-writing instruction.
REQ-010 SHALL have port sel_stall, output, 1, freeze fetch/decode/execute this cycle.
REQ-011 SHALL have ports mem_rd_en/mem_wr_en, output, 1 each, data-memory read/write strobes.
REQ-012 SHALL have ports instr_out, output, 32; wb_valid, sel_wb, en_wb, output, 1 each; registered writeback bundle (sel_wb=1 selects memory data).
REQ-013 SHALL have port mem_timeout, output, 1, sticky access-timeout flag.

Function
REQ-014 Decode fields: cond=[31:28], opcode=[27:21], rn=[19:16], rd=[15:12].
REQ-015 Classes: ALU = opcode[6]=0 and cond!=4'hF; LDR = (opcode[6:5]=11 and opcode[0]=1) or opcode[6:3]=1000; STR = opcode[6:5]=11 and opcode[0]=0; all else NONE.
REQ-016 Register R (instr + valid bit) SHALL hold the memory-stage instruction; rd_valid = R.valid and class ALU or LDR; rd = R.rd when rd_valid.
REQ-017 FSM states RUN, ACCESS, BUBBLE; state ACCESS iff R.valid and R class LDR/STR not yet acknowledged.
REQ-018 RUN: each edge instr_out<=R, wb_valid<=R.valid; R<=instr_in (valid=!branch_in); next state ACCESS if captured instruction valid and LDR/STR, else RUN.
REQ-019 ACCESS: mem_rd_en=LDR, mem_wr_en=STR, held combinationally until the edge where mem_ready=1; R held while mem_ready=0; wb_valid<=0 each waiting cycle.
REQ-020 lu_hit = R is LDR and ((exec_use[0] and exec_rn=R.rd) or (exec_use[1] and exec_rm=R.rd) or (exec_use[2] and exec_rs=R.rd)).
REQ-021 ACCESS with mem_ready=1: instr_out<=R, wb_valid<=1; if lu_hit then R<=NOP, next BUBBLE; else R<=instr_in per REQ-018 and next state per REQ-018.
REQ-022 BUBBLE: lasts exactly 1 cycle; R stays NOP; instr_out<=NOP, wb_valid<=0; next RUN.
REQ-023 sel_stall = (ACCESS and (!mem_ready or lu_hit)) or BUBBLE; when sel_stall=1 instr_in is not captured and branch_in is ignored.
REQ-024 sel_wb<=captured class LDR; en_wb<=wb_valid-bound instruction is ALU or LDR; STR and NOP give en_wb=0.
REQ-025 4-bit wait_cnt clears on ACCESS entry, increments each ACCESS cycle with mem_ready=0, saturates at 15; reaching 15 sets mem_timeout, cleared only by reset; access keeps waiting.
REQ-026 Load-use latency: LDR followed by dependent instruction yields exactly 1 stall cycle beyond the ack cycle; no-wait STR adds 0 stall cycles beyond the ack cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state RUN, R=NOP, instr_out=0, wb_valid=0, sel_wb=0, en_wb=0, wait_cnt=0, mem_timeout=0, hence rd=0, rd_valid=0, sel_stall=0, mem_rd_en=0, mem_wr_en=0, including mid-ACCESS.

Verification
REQ-028 ALU instr rd=3 captured -> next cycle rd=3, rd_valid=1; following cycle instr_out=it, wb_valid=1, en_wb=1, sel_wb=0.
REQ-029 LDR rd=5, mem_ready low 2 cycles then high, exec_use=000 -> sel_stall=1 for 2 cycles, 0 on ack cycle; mem_rd_en=1 for 3 cycles; then sel_wb=1, en_wb=1.
REQ-030 Same LDR, mem_ready=1 immediately, exec_use=001, exec_rn=5 -> sel_stall=1 on ack cycle and BUBBLE cycle, then 0; one NOP in writeback.
REQ-031 STR with branch_in=1 at capture -> R=NOP, mem_wr_en never asserted, wb_valid=0 next cycle.
REQ-032 STR with mem_ready held low 20 cycles -> mem_timeout=1 from 15th wait cycle, stays 1 after ack; rst_n pulse clears it.
REQ-033 rst_n asserted mid-ACCESS -> mem_rd_en, mem_wr_en, sel_stall drop to 0 without clock edge; after release state RUN, outputs zero.

Source files
------------

// File: rtl/memory_unit.sv
// Memory stage: holds one instruction in R, drives data-memory strobes for
// loads/stores, stalls upstream on outstanding accesses and load-use hazards.
module memory_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        branch_in,
  input  logic [3:0]  exec_rn,
  input  logic [3:0]  exec_rm,
  input  logic [3:0]  exec_rs,
  input  logic [2:0]  exec_use,
  input  logic        mem_ready,
  output logic [3:0]  rd,
  output logic        rd_valid,
  output logic        sel_stall,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] instr_out,
  output logic        wb_valid,
  output logic        sel_wb,
  output logic        en_wb,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {RUN, ACCESS, BUBBLE} state_e;

  state_e      state_q, state_d;
  logic [31:0] r_instr_q;
  logic        r_valid_q;
  logic [31:0] instr_out_q;
  logic        wb_valid_q, sel_wb_q, en_wb_q;
  logic [3:0]  wait_cnt_q;
  logic        mem_timeout_q;

  logic r_alu, r_ldr, r_str, in_mem, lu_hit, ack, waiting, capture, wb_load;

  function automatic logic is_alu(input logic [31:0] i);
    return (i[27] == 1'b0) && (i[31:28] != 4'hF);
  endfunction

  function automatic logic is_ldr(input logic [31:0] i);
    return ((i[27:26] == 2'b11) && i[21]) || (i[27:24] == 4'b1000);
  endfunction

  function automatic logic is_str(input logic [31:0] i);
    return (i[27:26] == 2'b11) && !i[21];
  endfunction

  always_comb begin
    r_alu   = is_alu(r_instr_q);
    r_ldr   = is_ldr(r_instr_q);
    r_str   = is_str(r_instr_q);
    in_mem  = !branch_in && (is_ldr(instr_in) || is_str(instr_in));
    lu_hit  = r_valid_q && r_ldr &&
              ((exec_use[0] && (exec_rn == r_instr_q[15:12])) ||
               (exec_use[1] && (exec_rm == r_instr_q[15:12])) ||
               (exec_use[2] && (exec_rs == r_instr_q[15:12])));
    ack     = (state_q == ACCESS) && mem_ready;
    waiting = (state_q == ACCESS) && !mem_ready;
    // R advances in RUN, or on an acknowledged access with no dependent consumer
    capture = (state_q == RUN) || (ack && !lu_hit);
    wb_load = (state_q == RUN) || ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = in_mem ? ACCESS : RUN;
      ACCESS: begin
        if (!mem_ready)  state_d = ACCESS;
        else if (lu_hit) state_d = BUBBLE;
        else             state_d = in_mem ? ACCESS : RUN;
      end
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == ACCESS) && r_ldr;
    mem_wr_en = (state_q == ACCESS) && r_str;
    sel_stall = ((state_q == ACCESS) && (!mem_ready || lu_hit)) || (state_q == BUBBLE);
    rd_valid  = r_valid_q && (r_alu || r_ldr);
    rd        = rd_valid ? r_instr_q[15:12] : 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_q     <= '0;
      r_valid_q     <= 1'b0;
      instr_out_q   <= '0;
      wb_valid_q    <= 1'b0;
      sel_wb_q      <= 1'b0;
      en_wb_q       <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (wb_load) begin
        instr_out_q <= r_instr_q;
        wb_valid_q  <= r_valid_q;
        sel_wb_q    <= r_valid_q && r_ldr;
        en_wb_q     <= r_valid_q && (r_alu || r_ldr);
      end else begin
        instr_out_q <= '0;
        wb_valid_q  <= 1'b0;
        sel_wb_q    <= 1'b0;
        en_wb_q     <= 1'b0;
      end

      if (capture) begin
        r_instr_q <= branch_in ? '0 : instr_in;
        r_valid_q <= !branch_in;
      end else if (ack && lu_hit) begin
        r_instr_q <= '0;
        r_valid_q <= 1'b0;
      end

      // flag rises on the same edge the counter reaches 15
      if (capture) begin
        wait_cnt_q <= '0;
      end else if (waiting) begin
        if (wait_cnt_q != 4'hF) wait_cnt_q <= wait_cnt_q + 4'd1;
        if (wait_cnt_q >= 4'd14) mem_timeout_q <= 1'b1;
      end
    end
  end

  assign instr_out   = instr_out_q;
  assign wb_valid    = wb_valid_q;
  assign sel_wb      = sel_wb_q;
  assign en_wb       = en_wb_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_memory_unit.sv
// Randomized and directed bench for memory_unit against a cycle-level
// behavioural model of the memory-stage rules.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        branch_in;
  logic [3:0]  exec_rn, exec_rm, exec_rs;
  logic [2:0]  exec_use;
  logic        mem_ready;
  logic [3:0]  rd;
  logic        rd_valid, sel_stall, mem_rd_en, mem_wr_en;
  logic [31:0] instr_out;
  logic        wb_valid, sel_wb, en_wb, mem_timeout;

  always #5 clk = ~clk;

  memory_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .branch_in(branch_in),
    .exec_rn(exec_rn), .exec_rm(exec_rm), .exec_rs(exec_rs), .exec_use(exec_use),
    .mem_ready(mem_ready), .rd(rd), .rd_valid(rd_valid), .sel_stall(sel_stall),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .instr_out(instr_out),
    .wb_valid(wb_valid), .sel_wb(sel_wb), .en_wb(en_wb), .mem_timeout(mem_timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          n_stall, n_rd, n_wr;

  // model state: pending access, bubble pending, R, writeback bundle, timeout
  logic [31:0] m_r, m_out;
  bit          m_rv, m_wbv, m_selwb, m_enwb, m_pend, m_bub, m_to;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opc(input logic [31:0] i);
    return int'(i[27:21]);
  endfunction

  function automatic bit m_ldr(input logic [31:0] i);
    return (opc(i) >= 96 && opc(i) % 2 == 1) || (opc(i) >= 64 && opc(i) < 72);
  endfunction

  function automatic bit m_str(input logic [31:0] i);
    return opc(i) >= 96 && opc(i) % 2 == 0;
  endfunction

  function automatic bit m_alu(input logic [31:0] i);
    return opc(i) < 64 && i[31:28] != 4'hF;
  endfunction

  function automatic logic [31:0] mk(input int cond, input int op, input int rdn);
    logic [31:0] v;
    v = '0;
    v[31:28] = 4'(cond);
    v[27:21] = 7'(op);
    v[15:12] = 4'(rdn);
    return v;
  endfunction

  task automatic model_reset;
    m_r = '0; m_out = '0; m_rv = 0; m_wbv = 0; m_selwb = 0; m_enwb = 0;
    m_pend = 0; m_bub = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rd_en", 32'(mem_rd_en), 0);
    check_eq("rst_wr_en", 32'(mem_wr_en), 0);
    check_eq("rst_stall", 32'(sel_stall), 0);
    check_eq("rst_rd", {27'd0, rd_valid, rd}, 0);
    check_eq("rst_out", instr_out, 0);
    check_eq("rst_wb", {wb_valid, sel_wb, en_wb, mem_timeout}, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input logic [31:0] ins, input logic br, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [3:0] rs, input logic [2:0] use_v,
                      input logic rdy);
    bit hit, rdv, stall, done, take, npend;
    @(negedge clk);
    instr_in = ins; branch_in = br; exec_rn = rn; exec_rm = rm; exec_rs = rs;
    exec_use = use_v; mem_ready = rdy;
    #1;
    hit   = m_rv && m_ldr(m_r) &&
            ((use_v[0] && rn == m_r[15:12]) || (use_v[1] && rm == m_r[15:12]) ||
             (use_v[2] && rs == m_r[15:12]));
    rdv   = m_rv && (m_alu(m_r) || m_ldr(m_r));
    stall = (m_pend && (!rdy || hit)) || m_bub;
    check_eq("rd_valid", 32'(rd_valid), 32'(rdv));
    check_eq("rd", 32'(rd), rdv ? 32'(m_r[15:12]) : 0);
    check_eq("sel_stall", 32'(sel_stall), 32'(stall));
    check_eq("mem_rd_en", 32'(mem_rd_en), 32'(m_pend && m_ldr(m_r)));
    check_eq("mem_wr_en", 32'(mem_wr_en), 32'(m_pend && m_str(m_r)));
    check_eq("instr_out", instr_out, m_out);
    check_eq("wb_bundle", {wb_valid, sel_wb, en_wb}, {m_wbv, m_selwb, m_enwb});
    check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
    n_stall += int'(sel_stall); n_rd += int'(mem_rd_en); n_wr += int'(mem_wr_en);

    done = m_pend && rdy;
    take = (!m_pend && !m_bub) || (done && !hit);
    if ((!m_pend && !m_bub) || done) begin
      m_out = m_r; m_wbv = m_rv; m_selwb = m_rv && m_ldr(m_r); m_enwb = rdv;
    end else begin
      m_out = '0; m_wbv = 0; m_selwb = 0; m_enwb = 0;
    end
    if (m_pend && !rdy) begin
      if (m_cnt + 1 >= 15) m_to = 1;
      m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end else if (take) begin
      m_cnt = 0;
    end
    npend = take ? (!br && (m_ldr(ins) || m_str(ins))) : (m_pend && !rdy);
    m_bub = done && hit;
    if (take) begin
      m_r = br ? '0 : ins; m_rv = !br;
    end else if (done && hit) begin
      m_r = '0; m_rv = 0;
    end
    m_pend = npend;
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    int k, cond, op;
    logic [31:0] v;
    k = int'($urandom_range(0, 4));
    cond = int'($urandom_range(0, 14));
    case (k)
      0: op = int'($urandom_range(0, 63));
      1: op = 97 + 2 * int'($urandom_range(0, 15));
      2: op = 96 + 2 * int'($urandom_range(0, 15));
      3: op = 64 + int'($urandom_range(0, 7));
      default: begin
        if ($urandom_range(0, 1) == 0) begin cond = 15; op = int'($urandom_range(0, 63)); end
        else op = int'($urandom_range(72, 95));
      end
    endcase
    v = $urandom();
    v[31:28] = 4'(cond);
    v[27:21] = 7'(op);
    v[15:12] = 4'($urandom_range(0, 3));
    return v;
  endfunction

  localparam int ALU = 4, LDR = 97, STR = 96;
  logic [31:0] alu3, ldr5, dep, str1;

  initial begin
    rst_n = 1'b0; instr_in = '0; branch_in = 1'b0; exec_rn = '0; exec_rm = '0;
    exec_rs = '0; exec_use = '0; mem_ready = 1'b0;
    alu3 = mk(14, ALU, 3); ldr5 = mk(14, LDR, 5); dep = mk(14, ALU, 7); str1 = mk(14, STR, 1);
    #2 apply_reset();

    step(alu3, 0, 0, 0, 0, 0, 1);
    #1 check_eq("alu_rd", {27'd0, rd_valid, rd}, {27'd0, 1'b1, 4'd3});
    step('0, 0, 0, 0, 0, 0, 1);
    #1 check_eq("alu_wb", instr_out, alu3);
    check_eq("alu_flags", {wb_valid, en_wb, sel_wb}, 3'b110);

    apply_reset();
    step(ldr5, 0, 0, 0, 0, 0, 1);
    n_stall = 0; n_rd = 0;
    step(dep, 0, 0, 0, 0, 0, 0);
    step(dep, 0, 0, 0, 0, 0, 0);
    step(dep, 0, 0, 0, 0, 0, 1);
    check_eq("ldr_wait_stalls", 32'(n_stall), 2);
    check_eq("ldr_rd_en_cycles", 32'(n_rd), 3);
    #1 check_eq("ldr_wb", {sel_wb, en_wb}, 2'b11);

    apply_reset();
    step(ldr5, 0, 0, 0, 0, 0, 1);
    n_stall = 0;
    step(dep, 0, 5, 0, 0, 3'b001, 1);
    step(dep, 0, 5, 0, 0, 3'b001, 1);
    #1 check_eq("bubble_wb", {instr_out, wb_valid}, 0);
    step(dep, 0, 5, 0, 0, 3'b001, 1);
    check_eq("loaduse_stalls", 32'(n_stall), 2);

    apply_reset();
    n_wr = 0;
    step(str1, 1, 0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 0, 0, 1);
    #1 check_eq("flush_wb_valid", 32'(wb_valid), 0);
    step('0, 0, 0, 0, 0, 0, 1);
    check_eq("flush_no_wr", 32'(n_wr), 0);

    apply_reset();
    step(str1, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      step(dep, 0, 0, 0, 0, 0, 0);
      if (i == 14) #1 check_eq("timeout_at14", 32'(mem_timeout), 0);
      if (i == 15) #1 check_eq("timeout_at15", 32'(mem_timeout), 1);
    end
    step(dep, 0, 0, 0, 0, 0, 1);
    #1 check_eq("timeout_sticky", 32'(mem_timeout), 1);
    apply_reset();

    step(ldr5, 0, 0, 0, 0, 0, 1);
    step(dep, 0, 0, 0, 0, 0, 0);
    #1 check_eq("mid_access_rd_en", 32'(mem_rd_en), 1);
    apply_reset();

    for (int i = 0; i < 1500; i++) begin
      step(rand_instr(), ($urandom_range(0, 99) < 15), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom()),
           ($urandom_range(0, 99) < 55));
      if (i == 700) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
